// File: rtl/mma_tile_sequencer.sv
// GEMM tile sequencer: latches a job configuration on calc_start and issues one
// valid/ready command per TILE_M x TILE_N output tile, row-major with columns inner.
module mma_tile_sequencer #(
   parameter int unsigned REG_WIDTH = 32,
   parameter int unsigned TILE_M    = 4,
   parameter int unsigned TILE_N    = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              calc_start,
   input  logic                              cfg_16bits_ia,
   output logic                              sa_ready,
   input  logic        [REG_WIDTH-1:0]       lhs_base,
   input  logic        [REG_WIDTH-1:0]       rhs_base,
   input  logic        [REG_WIDTH-1:0]       dst_base,
   input  logic        [REG_WIDTH-1:0]       bias_base,
   input  logic signed [REG_WIDTH-1:0]       lhs_zp,
   input  logic signed [REG_WIDTH-1:0]       rhs_zp,
   input  logic signed [REG_WIDTH-1:0]       dst_zp,
   input  logic signed [REG_WIDTH-1:0]       q_mult_pt,
   input  logic signed [REG_WIDTH-1:0]       q_shift_pt,
   input  logic                              use_per_channel,
   input  logic        [REG_WIDTH-1:0]       k,
   input  logic        [REG_WIDTH-1:0]       n,
   input  logic        [REG_WIDTH-1:0]       m,
   input  logic        [REG_WIDTH-1:0]       lhs_row_stride_b,
   input  logic        [REG_WIDTH-1:0]       dst_row_stride_b,
   input  logic        [REG_WIDTH-1:0]       rhs_row_stride_b,
   input  logic signed [REG_WIDTH-1:0]       act_min,
   input  logic signed [REG_WIDTH-1:0]       act_max,
   output logic                              tile_valid,
   input  logic                              tile_ready,
   output logic        [REG_WIDTH-1:0]       tile_lhs_addr,
   output logic        [REG_WIDTH-1:0]       tile_rhs_addr,
   output logic        [REG_WIDTH-1:0]       tile_dst_addr,
   output logic        [REG_WIDTH-1:0]       tile_bias_addr,
   output logic        [$clog2(TILE_M+1)-1:0] tile_rows,
   output logic        [$clog2(TILE_N+1)-1:0] tile_cols,
   output logic        [REG_WIDTH-1:0]       tile_k_bytes,
   output logic signed [REG_WIDTH-1:0]       cfg_q_lhs_zp,
   output logic signed [REG_WIDTH-1:0]       cfg_q_rhs_zp,
   output logic signed [REG_WIDTH-1:0]       cfg_q_dst_zp,
   output logic signed [REG_WIDTH-1:0]       cfg_q_q_mult_pt,
   output logic signed [REG_WIDTH-1:0]       cfg_q_q_shift_pt,
   output logic                              cfg_q_use_per_channel,
   output logic signed [REG_WIDTH-1:0]       cfg_q_act_min,
   output logic signed [REG_WIDTH-1:0]       cfg_q_act_max,
   output logic                              cfg_q_cfg_16bits_ia,
   output logic                              done
);

   localparam int unsigned RowW = $clog2(TILE_M + 1);
   localparam int unsigned ColW = $clog2(TILE_N + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StFin} state_e;

   state_e               state_q;
   logic [REG_WIDTH-1:0] row0_q, col0_q, m_q, n_q;
   logic [REG_WIDTH-1:0] lhs_stride_q, dst_stride_q, rhs_stride_q;
   logic [REG_WIDTH-1:0] rhs_base_q, bias_base_q, dst_row_q;

   logic [REG_WIDTH:0]   col_sum, row_sum;
   logic                 col_wrap, last_tile;
   logic [REG_WIDTH-1:0] row0_d, col0_d;
   logic [RowW-1:0]      rows_d;
   logic [ColW-1:0]      cols_d;
   logic [REG_WIDTH-1:0] lhs_step, dst_step, rhs_step;

   function automatic logic [RowW-1:0] clamp_rows(input logic [REG_WIDTH-1:0] rem);
      return (rem >= REG_WIDTH'(TILE_M)) ? RowW'(TILE_M) : RowW'(rem);
   endfunction

   function automatic logic [ColW-1:0] clamp_cols(input logic [REG_WIDTH-1:0] rem);
      return (rem >= REG_WIDTH'(TILE_N)) ? ColW'(TILE_N) : ColW'(rem);
   endfunction

   // Sums are one bit wider so the end-of-row/job compares cannot wrap.
   always_comb begin
      col_sum   = {1'b0, col0_q} + (REG_WIDTH+1)'(TILE_N);
      row_sum   = {1'b0, row0_q} + (REG_WIDTH+1)'(TILE_M);
      col_wrap  = (col_sum >= {1'b0, n_q});
      last_tile = col_wrap && (row_sum >= {1'b0, m_q});
      row0_d    = col_wrap ? row_sum[REG_WIDTH-1:0] : row0_q;
      col0_d    = col_wrap ? '0 : col_sum[REG_WIDTH-1:0];
      rows_d    = clamp_rows(m_q - row0_d);
      cols_d    = clamp_cols(n_q - col0_d);
      lhs_step  = lhs_stride_q * REG_WIDTH'(TILE_M);
      dst_step  = dst_stride_q * REG_WIDTH'(TILE_M);
      rhs_step  = rhs_stride_q * REG_WIDTH'(TILE_N);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q               <= StIdle;
         sa_ready              <= 1'b1;
         tile_valid            <= 1'b0;
         done                  <= 1'b0;
         row0_q                <= '0;
         col0_q                <= '0;
         m_q                   <= '0;
         n_q                   <= '0;
         lhs_stride_q          <= '0;
         dst_stride_q          <= '0;
         rhs_stride_q          <= '0;
         rhs_base_q            <= '0;
         bias_base_q           <= '0;
         dst_row_q             <= '0;
         tile_lhs_addr         <= '0;
         tile_rhs_addr         <= '0;
         tile_dst_addr         <= '0;
         tile_bias_addr        <= '0;
         tile_rows             <= '0;
         tile_cols             <= '0;
         tile_k_bytes          <= '0;
         cfg_q_lhs_zp          <= '0;
         cfg_q_rhs_zp          <= '0;
         cfg_q_dst_zp          <= '0;
         cfg_q_q_mult_pt       <= '0;
         cfg_q_q_shift_pt      <= '0;
         cfg_q_use_per_channel <= 1'b0;
         cfg_q_act_min         <= '0;
         cfg_q_act_max         <= '0;
         cfg_q_cfg_16bits_ia   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (calc_start) begin
                  sa_ready              <= 1'b0;
                  row0_q                <= '0;
                  col0_q                <= '0;
                  m_q                   <= m;
                  n_q                   <= n;
                  lhs_stride_q          <= lhs_row_stride_b;
                  dst_stride_q          <= dst_row_stride_b;
                  rhs_stride_q          <= rhs_row_stride_b;
                  rhs_base_q            <= rhs_base;
                  bias_base_q           <= bias_base;
                  dst_row_q             <= dst_base;
                  tile_lhs_addr         <= lhs_base;
                  tile_rhs_addr         <= rhs_base;
                  tile_dst_addr         <= dst_base;
                  tile_bias_addr        <= bias_base;
                  tile_rows             <= clamp_rows(m);
                  tile_cols             <= clamp_cols(n);
                  tile_k_bytes          <= cfg_16bits_ia ? (k << 1) : k;
                  cfg_q_lhs_zp          <= lhs_zp;
                  cfg_q_rhs_zp          <= rhs_zp;
                  cfg_q_dst_zp          <= dst_zp;
                  cfg_q_q_mult_pt       <= q_mult_pt;
                  cfg_q_q_shift_pt      <= q_shift_pt;
                  cfg_q_use_per_channel <= use_per_channel;
                  cfg_q_act_min         <= act_min;
                  cfg_q_act_max         <= act_max;
                  cfg_q_cfg_16bits_ia   <= cfg_16bits_ia;
                  if (m == '0 || n == '0 || k == '0) begin
                     state_q <= StFin;
                     done    <= 1'b1;
                  end else begin
                     state_q    <= StIssue;
                     tile_valid <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (tile_ready) begin
                  if (last_tile) begin
                     state_q    <= StFin;
                     tile_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     row0_q    <= row0_d;
                     col0_q    <= col0_d;
                     tile_rows <= rows_d;
                     tile_cols <= cols_d;
                     // Addresses advance incrementally so no runtime multiplier is needed.
                     if (col_wrap) begin
                        tile_lhs_addr  <= tile_lhs_addr + lhs_step;
                        dst_row_q      <= dst_row_q + dst_step;
                        tile_dst_addr  <= dst_row_q + dst_step;
                        tile_rhs_addr  <= rhs_base_q;
                        tile_bias_addr <= bias_base_q;
                     end else begin
                        tile_dst_addr  <= tile_dst_addr + REG_WIDTH'(TILE_N);
                        tile_rhs_addr  <= tile_rhs_addr + rhs_step;
                        tile_bias_addr <= tile_bias_addr + REG_WIDTH'(4 * TILE_N);
                     end
                  end
               end
            end
            StFin: begin
               state_q  <= StIdle;
               sa_ready <= 1'b1;
            end
            default: begin
               state_q    <= StIdle;
               sa_ready   <= 1'b1;
               tile_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mma_tile_sequencer.sv
// Directed bench for mma_tile_sequencer: single tile, ragged 2x2 tiling, 16-bit k,
// back-pressure, empty job and mid-job reset.
module tb_mma_tile_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, calc_start, cfg_16bits_ia, use_per_channel, tile_ready;
   logic [31:0] lhs_base, rhs_base, dst_base, bias_base;
   logic [31:0] lhs_zp, rhs_zp, dst_zp, q_mult_pt, q_shift_pt;
   logic [31:0] k, n, m, lhs_row_stride_b, dst_row_stride_b, rhs_row_stride_b;
   logic [31:0] act_min, act_max;
   logic        sa_ready, tile_valid, done;
   logic [31:0] tile_lhs_addr, tile_rhs_addr, tile_dst_addr, tile_bias_addr, tile_k_bytes;
   logic [2:0]  tile_rows, tile_cols;
   logic [31:0] cfg_q_lhs_zp, cfg_q_rhs_zp, cfg_q_dst_zp, cfg_q_q_mult_pt, cfg_q_q_shift_pt;
   logic [31:0] cfg_q_act_min, cfg_q_act_max;
   logic        cfg_q_use_per_channel, cfg_q_cfg_16bits_ia;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mma_tile_sequencer #(.REG_WIDTH(32), .TILE_M(4), .TILE_N(4)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .calc_start            (calc_start),
      .cfg_16bits_ia         (cfg_16bits_ia),
      .sa_ready              (sa_ready),
      .lhs_base              (lhs_base),
      .rhs_base              (rhs_base),
      .dst_base              (dst_base),
      .bias_base             (bias_base),
      .lhs_zp                (lhs_zp),
      .rhs_zp                (rhs_zp),
      .dst_zp                (dst_zp),
      .q_mult_pt             (q_mult_pt),
      .q_shift_pt            (q_shift_pt),
      .use_per_channel       (use_per_channel),
      .k                     (k),
      .n                     (n),
      .m                     (m),
      .lhs_row_stride_b      (lhs_row_stride_b),
      .dst_row_stride_b      (dst_row_stride_b),
      .rhs_row_stride_b      (rhs_row_stride_b),
      .act_min               (act_min),
      .act_max               (act_max),
      .tile_valid            (tile_valid),
      .tile_ready            (tile_ready),
      .tile_lhs_addr         (tile_lhs_addr),
      .tile_rhs_addr         (tile_rhs_addr),
      .tile_dst_addr         (tile_dst_addr),
      .tile_bias_addr        (tile_bias_addr),
      .tile_rows             (tile_rows),
      .tile_cols             (tile_cols),
      .tile_k_bytes          (tile_k_bytes),
      .cfg_q_lhs_zp          (cfg_q_lhs_zp),
      .cfg_q_rhs_zp          (cfg_q_rhs_zp),
      .cfg_q_dst_zp          (cfg_q_dst_zp),
      .cfg_q_q_mult_pt       (cfg_q_q_mult_pt),
      .cfg_q_q_shift_pt      (cfg_q_q_shift_pt),
      .cfg_q_use_per_channel (cfg_q_use_per_channel),
      .cfg_q_act_min         (cfg_q_act_min),
      .cfg_q_act_max         (cfg_q_act_max),
      .cfg_q_cfg_16bits_ia   (cfg_q_cfg_16bits_ia),
      .done                  (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tile(input string tag, input logic [31:0] lhs, input logic [31:0] rhs,
                           input logic [31:0] dst, input logic [31:0] bias,
                           input logic [31:0] rows, input logic [31:0] cols);
      chk({tag, "_valid"}, {31'b0, tile_valid}, 32'd1);
      chk({tag, "_lhs"}, tile_lhs_addr, lhs);
      chk({tag, "_rhs"}, tile_rhs_addr, rhs);
      chk({tag, "_dst"}, tile_dst_addr, dst);
      chk({tag, "_bias"}, tile_bias_addr, bias);
      chk({tag, "_rows"}, {29'b0, tile_rows}, rows);
      chk({tag, "_cols"}, {29'b0, tile_cols}, cols);
   endtask

   task automatic clear_cfg();
      cfg_16bits_ia = 0; use_per_channel = 0;
      lhs_base = 0; rhs_base = 0; dst_base = 0; bias_base = 0;
      lhs_zp = 0; rhs_zp = 0; dst_zp = 0; q_mult_pt = 0; q_shift_pt = 0;
      k = 0; n = 0; m = 0;
      lhs_row_stride_b = 0; dst_row_stride_b = 0; rhs_row_stride_b = 0;
      act_min = 0; act_max = 0;
   endtask

   initial begin
      rst_n = 0; calc_start = 0; tile_ready = 0;
      clear_cfg();
      tick(); tick();
      chk("rst_sa_ready", {31'b0, sa_ready}, 32'd1);
      chk("rst_valid", {31'b0, tile_valid}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_lhs", tile_lhs_addr, 32'd0);
      chk("rst_act_max", cfg_q_act_max, 32'd0);
      rst_n = 1;
      tick();

      // Single 4x4 tile.
      m = 4; n = 4; k = 16; lhs_base = 32'h1000;
      lhs_row_stride_b = 16; dst_row_stride_b = 16; rhs_row_stride_b = 16;
      calc_start = 1;
      tick();
      calc_start = 0;
      chk("t1_sa_ready", {31'b0, sa_ready}, 32'd0);
      chk_tile("t1", 32'h1000, 0, 0, 0, 4, 4);
      chk("t1_kbytes", tile_k_bytes, 32'd16);
      tile_ready = 1;
      tick();
      chk("t1_valid_off", {31'b0, tile_valid}, 32'd0);
      chk("t1_done", {31'b0, done}, 32'd1);
      tick();
      chk("t1_done_off", {31'b0, done}, 32'd0);
      chk("t1_sa_back", {31'b0, sa_ready}, 32'd1);

      // 6x5 output: four ragged tiles back to back.
      clear_cfg();
      m = 6; n = 5; k = 8;
      lhs_base = 32'h100; rhs_base = 32'h400; dst_base = 32'h2000; bias_base = 32'h800;
      lhs_row_stride_b = 16; rhs_row_stride_b = 8; dst_row_stride_b = 8;
      lhs_zp = 32'hFFFF_FFFD; use_per_channel = 1; act_min = 32'hFFFF_FF80; act_max = 127;
      calc_start = 1;
      tick();
      calc_start = 0;
      clear_cfg();
      chk_tile("t2a", 32'h100, 32'h400, 32'h2000, 32'h800, 4, 4);
      chk("t2_lhs_zp", cfg_q_lhs_zp, 32'hFFFF_FFFD);
      chk("t2_per_ch", {31'b0, cfg_q_use_per_channel}, 32'd1);
      chk("t2_act_min", cfg_q_act_min, 32'hFFFF_FF80);
      tick();
      chk_tile("t2b", 32'h100, 32'h420, 32'h2004, 32'h810, 4, 1);
      tick();
      chk_tile("t2c", 32'h140, 32'h400, 32'h2020, 32'h800, 2, 4);
      tick();
      chk_tile("t2d", 32'h140, 32'h420, 32'h2024, 32'h810, 2, 1);
      tick();
      chk("t2_done", {31'b0, done}, 32'd1);
      chk("t2_valid_off", {31'b0, tile_valid}, 32'd0);
      chk("t2_act_max_held", cfg_q_act_max, 32'd127);
      tick();

      // 16-bit activations with back-pressure; a start pulse mid-stall is ignored.
      tile_ready = 0;
      m = 4; n = 4; k = 10; cfg_16bits_ia = 1; lhs_base = 32'h3000;
      calc_start = 1;
      tick();
      calc_start = 0;
      chk("t3_kbytes", tile_k_bytes, 32'd20);
      chk("t3_cfg16", {31'b0, cfg_q_cfg_16bits_ia}, 32'd1);
      clear_cfg();
      lhs_base = 32'h9999; m = 0; k = 3;
      for (int i = 0; i < 5; i++) begin
         calc_start = (i == 2);
         chk_tile("t3_stall", 32'h3000, 0, 0, 0, 4, 4);
         chk("t3_stall_kbytes", tile_k_bytes, 32'd20);
         chk("t3_stall_cfg16", {31'b0, cfg_q_cfg_16bits_ia}, 32'd1);
         tick();
      end
      calc_start = 0;
      chk_tile("t3_final", 32'h3000, 0, 0, 0, 4, 4);
      tile_ready = 1;
      tick();
      chk("t3_done", {31'b0, done}, 32'd1);
      tick();
      chk("t3_sa_back", {31'b0, sa_ready}, 32'd1);
      chk("t3_valid_idle", {31'b0, tile_valid}, 32'd0);

      // Empty job: m=0.
      clear_cfg();
      m = 0; n = 4; k = 4;
      calc_start = 1;
      tick();
      calc_start = 0;
      chk("t4_valid", {31'b0, tile_valid}, 32'd0);
      chk("t4_done", {31'b0, done}, 32'd1);
      chk("t4_sa_ready", {31'b0, sa_ready}, 32'd0);
      tick();
      chk("t4_done_off", {31'b0, done}, 32'd0);
      chk("t4_sa_back", {31'b0, sa_ready}, 32'd1);

      // Reset during the second tile, then restart from the origin.
      clear_cfg();
      m = 8; n = 4; k = 4; lhs_base = 32'h500; lhs_row_stride_b = 32; act_max = 55;
      calc_start = 1;
      tick();
      calc_start = 0;
      chk_tile("t5a", 32'h500, 0, 0, 0, 4, 4);
      tick();
      chk_tile("t5b", 32'h580, 0, 0, 0, 4, 4);
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("t5_rst_sa", {31'b0, sa_ready}, 32'd1);
      chk("t5_rst_valid", {31'b0, tile_valid}, 32'd0);
      chk("t5_rst_done", {31'b0, done}, 32'd0);
      chk("t5_rst_cfg", cfg_q_act_max, 32'd0);
      tile_ready = 0;
      tick();
      chk("t5_no_done", {31'b0, done}, 32'd0);
      calc_start = 1;
      tick();
      calc_start = 0;
      chk_tile("t5_restart", 32'h500, 0, 0, 0, 4, 4);
      tile_ready = 1;
      tick();
      chk_tile("t5_row1", 32'h580, 0, 0, 0, 4, 4);
      tick();
      chk("t5_done", {31'b0, done}, 32'd1);
      tick();
      chk("t5_sa_back", {31'b0, sa_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mma_tile_sequencer.md
Name: mma_tile_sequencer

Overview:
- Control front-end of the MMA top.
- When idle it accepts a calc_start pulse and latches the full GEMM configuration: base pointers, zero-points, quantization, dimensions, strides and clamp.
- It then walks the M x N output in TILE_M x TILE_N tiles and issues one valid/ready tile command per tile to the systolic array datapath.
- sa_ready tells the configuration driver when a new job is accepted.

Parameters:
- REG_WIDTH, 32, width of every configuration register and address.
- TILE_M, 4, systolic-array rows (output rows per tile).
- TILE_N, 4, systolic-array columns (output columns per tile).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- calc_start  input  1  start pulse; sampled only while sa_ready=1.
- cfg_16bits_ia  input  1  1 = 16-bit input activations (LHS), 0 = 8-bit.
- sa_ready  output  1  1 = idle, will accept calc_start.
- lhs_base, rhs_base, dst_base, bias_base  input  REG_WIDTH each  byte base addresses.
- lhs_zp, rhs_zp, dst_zp, q_mult_pt, q_shift_pt  input  REG_WIDTH each, signed  zero-points and quantization parameters.
- use_per_channel  input  1  per-channel quantization enable.
- k, n, m  input  REG_WIDTH each  reduction depth, output columns, output rows.
- lhs_row_stride_b, dst_row_stride_b, rhs_row_stride_b  input  REG_WIDTH each  row strides in bytes.
- act_min, act_max  input  REG_WIDTH each, signed  output clamp bounds.
- tile_valid  output  1  tile command valid.
- tile_ready  input  1  datapath accepts the command.
- tile_lhs_addr, tile_rhs_addr, tile_dst_addr, tile_bias_addr  output  REG_WIDTH each  tile start addresses.
- tile_rows  output  $clog2(TILE_M+1)  valid rows in the tile.
- tile_cols  output  $clog2(TILE_N+1)  valid columns in the tile.
- tile_k_bytes  output  REG_WIDTH  LHS bytes per row = k << cfg_16bits_ia.
- cfg_q_*  output  matching input width  registered copies of lhs_zp, rhs_zp, dst_zp, q_mult_pt, q_shift_pt, use_per_channel, act_min, act_max, cfg_16bits_ia.
- done  output  1  one-cycle pulse when the job finishes.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, sa_ready=1, tile_valid=0, done=0, all address, count and cfg_q_* registers cleared to 0. Reset mid-job aborts the job immediately; no done pulse.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - sa_ready=1.
  - calc_start=1 at a posedge latches every configuration input into cfg_q_* and internal registers, sets row0=0 and col0=0, and moves to ISSUE.
  - If any of m, n, k is 0, move to FIN instead.
  - sa_ready drops to 0 in the following cycle.
  - calc_start outside IDLE is ignored; configuration inputs are don't-care outside the start cycle.
- ISSUE:
  - tile_valid=1. Outputs are registered and stable while tile_valid=1 and tile_ready=0.
  - tile_lhs_addr = lhs_base + row0*lhs_row_stride_b.
  - tile_rhs_addr = rhs_base + col0*rhs_row_stride_b (RHS stored as n rows of k).
  - tile_dst_addr = dst_base + row0*dst_row_stride_b + col0 (int8 output).
  - tile_bias_addr = bias_base + 4*col0 (int32 bias).
  - tile_rows = min(TILE_M, m-row0); tile_cols = min(TILE_N, n-col0).
  - All arithmetic is unsigned modulo 2^REG_WIDTH; wrap-around is not flagged.
  - Handshake on tile_valid && tile_ready: advance col0 += TILE_N.
    - If col0+TILE_N >= n: col0=0 and row0 += TILE_M.
    - If also row0+TILE_M >= m: go to FIN.
    - Otherwise the next tile is presented in the very next cycle. Back-to-back handshakes give one tile per cycle.
- FIN: done=1 for exactly one cycle, then IDLE. sa_ready returns to 1 in the cycle after done.
- Ordering: row-major over tiles, with column tiles inner.
- Tile count = ceil(m/TILE_M) * ceil(n/TILE_N).
- Minimum latency: calc_start edge to first tile_valid = 1 cycle.
- cfg_q_* hold their latched values until the next accepted calc_start.

Test Plan:
- m=4, n=4, k=16, lhs_base=0x1000, bases otherwise 0, strides 16 -> exactly one tile: lhs=0x1000, rows=4, cols=4, tile_k_bytes=16; done pulses one cycle after the handshake; sa_ready back to 1 after done.
- m=6, n=5, TILE=4, dst_row_stride_b=8, dst_base=0x2000, tile_ready held 1 -> 4 tiles in order:
  - (0,0): dst=0x2000, rows=4, cols=4
  - (0,4): dst=0x2004, rows=4, cols=1
  - (4,0): dst=0x2020, rows=2, cols=4
  - (4,4): dst=0x2024, rows=2, cols=1
- cfg_16bits_ia=1, k=10 -> tile_k_bytes=20; cfg_q_cfg_16bits_ia=1.
- tile_ready held 0 for 5 cycles -> tile_valid stays 1 with all fields stable; a calc_start pulse in that window is ignored.
- m=0 -> no tile_valid; done pulses one cycle after start; sa_ready returns to 1.
- rst_n=0 during the second tile -> next cycle sa_ready=1, tile_valid=0, no done; a new calc_start restarts at row0=0, col0=0.
